// File: rtl/an_n37_pkg.sv
// Shared constants for the A=37 AN-code encoder and decoder array.
package an_n37_pkg;

    localparam int unsigned A         = 37;
    localparam int unsigned MSG_W     = 13;
    localparam int unsigned CW_W      = 18;
    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned MSG_MAX   = 7084;

    typedef enum logic {StFill, StHold} state_e;

endpackage

// File: rtl/an_encoder_n37.sv
// Combinational AN encoder: cw = m * 37 via shift-add, plus a range flag.
module an_encoder_n37
    import an_n37_pkg::*;
(
    input  logic [MSG_W-1:0] m,
    output logic [CW_W-1:0]  cw,
    output logic             in_range
);

    localparam logic [MSG_W-1:0] MaxMsg = MSG_W'(MSG_MAX);

    logic [CW_W:0] ext;
    logic [CW_W:0] wide;

    always_comb begin
        ext  = {{(CW_W + 1 - MSG_W){1'b0}}, m};
        wide = (ext << 5) + (ext << 2) + ext;
        cw   = wide[CW_W-1:0];
        // The carry bit is always clear for in-range messages.
        in_range = (m <= MaxMsg) && !wide[CW_W];
    end

endmodule

// File: rtl/an_frame_encoder_n37.sv
// Packs 16 AN-encoded messages into a frame for the 4x4 decoder array,
// with early flush (zero padding) and a valid/ready frame handshake.
module an_frame_encoder_n37
    import an_n37_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    input  logic [MSG_W-1:0]          msg_data,
    input  logic                      flush,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [NUM_SLOTS*CW_W-1:0] frame_cw,
    output logic [4:0]                frame_len,
    output logic [3:0]                frame_id,
    output logic                      range_err,
    output logic [7:0]                err_cnt
);

    state_e          state_q;
    logic [4:0]      count_q;
    logic [CW_W-1:0] slots_q [NUM_SLOTS];
    logic            frame_valid_q;
    logic [4:0]      frame_len_q;
    logic [3:0]      frame_id_q;
    logic            range_err_q;
    logic [7:0]      err_cnt_q;

    logic [CW_W-1:0] cw;
    logic            in_range;
    logic            accept;
    logic            store;
    logic [4:0]      count_nxt;
    logic            close;

    an_encoder_n37 u_enc (
        .m        (msg_data),
        .cw       (cw),
        .in_range (in_range)
    );

    always_comb begin
        accept    = msg_valid && (state_q == StFill);
        store     = accept && in_range;
        count_nxt = count_q + {4'b0, store};
        close     = (count_nxt == 5'(NUM_SLOTS)) || (flush && (count_nxt != 5'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StFill;
            count_q       <= 5'd0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= 5'd0;
            frame_id_q    <= 4'd0;
            range_err_q   <= 1'b0;
            err_cnt_q     <= 8'd0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            range_err_q <= accept && !in_range;
            if (accept && !in_range && (err_cnt_q != 8'hff)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            case (state_q)
                StFill: begin
                    // New codeword lands at count_q; padding only touches slots at or above count_nxt.
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (store && (5'(i) == count_q)) begin
                            slots_q[i] <= cw;
                        end else if (close && (5'(i) >= count_nxt)) begin
                            slots_q[i] <= '0;
                        end
                    end
                    count_q <= count_nxt;
                    if (close) begin
                        state_q       <= StHold;
                        frame_valid_q <= 1'b1;
                        frame_len_q   <= count_nxt;
                    end
                end
                StHold: begin
                    if (frame_ready) begin
                        state_q       <= StFill;
                        count_q       <= 5'd0;
                        frame_valid_q <= 1'b0;
                        frame_id_q    <= frame_id_q + 4'd1;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    always_comb begin
        frame_cw = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            frame_cw[i*CW_W +: CW_W] = slots_q[i];
        end
    end

    assign msg_ready   = (state_q == StFill);
    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign frame_id    = frame_id_q;
    assign range_err   = range_err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_an_frame_encoder_n37.sv
// Bench for an_frame_encoder_n37: queue-based frame model checked every cycle,
// plus directed literal expectations.
module tb_an_frame_encoder_n37;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [12:0]  msg_data = '0;
    logic         flush = 1'b0;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic [287:0] frame_cw;
    logic [4:0]   frame_len;
    logic [3:0]   frame_id;
    logic         range_err;
    logic [7:0]   err_cnt;

    int errors = 0;
    int checks = 0;

    an_frame_encoder_n37 dut (
        .clk         (clk),
        .rst         (rst),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_data    (msg_data),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_cw    (frame_cw),
        .frame_len   (frame_len),
        .frame_id    (frame_id),
        .range_err   (range_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: accepted codewords queue up until 16 arrive or a flush closes them.
    int unsigned pend[$];
    int unsigned m_slots[16];
    int          m_len = 0;
    int          m_fid = 0;
    int          m_errs = 0;
    bit          m_hold = 0;
    bit          m_rerr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            m_len  = 0;
            m_fid  = 0;
            m_errs = 0;
            m_hold = 0;
            m_rerr = 0;
        end else begin
            m_rerr = 0;
            if (!m_hold) begin
                if (msg_valid) begin
                    if (msg_data <= 13'd7084) pend.push_back(int'(msg_data) * 37);
                    else begin
                        m_rerr = 1;
                        if (m_errs < 255) m_errs++;
                    end
                end
                if (pend.size() == 16 || (flush && pend.size() > 0)) begin
                    for (int i = 0; i < 16; i++) m_slots[i] = (i < pend.size()) ? pend[i] : 0;
                    m_len  = pend.size();
                    m_hold = 1;
                    pend.delete();
                end
            end else if (frame_ready) begin
                m_hold = 0;
                m_fid  = (m_fid + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        logic [287:0] exp_cw;
        exp_cw = '0;
        for (int i = 0; i < 16; i++) exp_cw[i*18 +: 18] = 18'(m_slots[i]);
        check("msg_ready", msg_ready, !m_hold);
        check("frame_valid", frame_valid, m_hold);
        check("range_err", range_err, m_rerr);
        check("err_cnt", err_cnt, m_errs);
        check("frame_id", frame_id, m_fid);
        if (m_hold) begin
            check("frame_len", frame_len, m_len);
            check("frame_cw", frame_cw, exp_cw);
        end
    end

    function automatic logic [17:0] slot(input int i);
        return frame_cw[i*18 +: 18];
    endfunction

    task automatic send(input int m, input bit fl);
        msg_valid = 1'b1;
        msg_data  = 13'(m);
        flush     = fl;
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic idle(input bit fl);
        flush = fl;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic pop();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_msg_ready", msg_ready, 1);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_frame_id", frame_id, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_cw", frame_cw, 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame 0..15, frame_ready high throughout.
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(i, 0);
        check("f0_not_yet", frame_valid, 0);
        send(15, 0);
        check("f0_valid", frame_valid, 1);
        check("f0_len", frame_len, 16);
        check("f0_id", frame_id, 0);
        check("f0_slot1", slot(1), 37);
        check("f0_slot15", slot(15), 555);
        check("f0_msg_ready", msg_ready, 0);
        @(posedge clk);
        #1;
        check("f0_popped_ready", msg_ready, 1);
        for (int i = 16; i < 32; i++) send(i, 0);
        check("f1_id", frame_id, 1);
        check("f1_slot0", slot(0), 592);
        @(posedge clk);
        #1;
        frame_ready = 1'b0;

        // Range boundary and error counter.
        send(7084, 0);
        send(7085, 0);
        check("rng_pulse", range_err, 1);
        check("rng_cnt", err_cnt, 1);
        idle(1);
        check("rng_pulse_end", range_err, 0);
        check("rng_len", frame_len, 1);
        check("rng_slot0", slot(0), 262108);
        pop();
        for (int i = 0; i < 299; i++) send(7085 + (i % 1000), 0);
        check("err_sat", err_cnt, 255);
        check("err_no_frame", frame_valid, 0);

        // Flush with count 0 is ignored.
        idle(1);
        check("flush_empty", frame_valid, 0);

        // 1,2,3 then flush; hold 10 cycles with msg_valid asserted.
        send(1, 0);
        send(2, 0);
        send(3, 0);
        idle(1);
        check("fl_len", frame_len, 3);
        check("fl_slot2", slot(2), 111);
        check("fl_slot3", slot(3), 0);
        check("fl_slot15", slot(15), 0);
        msg_valid = 1'b1;
        msg_data  = 13'd9;
        repeat (10) idle(0);
        msg_valid = 1'b0;
        check("hold_ready", msg_ready, 0);
        check("hold_slot0", slot(0), 37);
        pop();
        check("hold_release", msg_ready, 1);

        // Flush together with the 3rd message.
        send(4, 0);
        send(5, 0);
        send(6, 1);
        check("fl3_len", frame_len, 3);
        check("fl3_slot2", slot(2), 222);
        pop();

        // Flush together with the 16th message: no padding.
        for (int i = 0; i < 15; i++) send(200 + i, 0);
        send(215, 1);
        check("fl16_len", frame_len, 16);
        check("fl16_slot15", slot(15), 7955);
        pop();

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 5; i++) send(50 + i, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_frame_id", frame_id, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_msg_ready", msg_ready, 1);
        check("arst_frame_valid", frame_valid, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send(100 + i, 0);
        begin
            int n = 0;
            while (!frame_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("arst_frame_seen", frame_valid, 1);
        end
        check("arst_id0", frame_id, 0);
        check("arst_slot0", slot(0), 3700);
        check("arst_slot15", slot(15), 4255);
        pop();
        idle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
